// File: rtl/iir_result_decimator.sv
// iir_result_decimator: accumulate-and-dump decimator for the IIR filter result stream.
// Each block of DEC enabled samples is summed, then rounded (half up), shifted right by
// SHIFT, saturated to OUT_W bits and buffered in a show-ahead FIFO.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear            synchronous clear of datapath, FIFO and flags
//   in_en, in_data   filter result and its enable
//   out_valid/ready  FIFO head handshake, out_data is the head (0 when empty)
//   fifo_level       entries held
//   overflow         sticky, a decimated sample was dropped on a full FIFO
//   sat              pulse, the sample about to be written was clipped
module iir_result_decimator #(
    parameter int unsigned IN_W       = 24,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned DEC        = 4,
    parameter int unsigned SHIFT      = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            in_en,
    input  logic signed [IN_W-1:0]          in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [OUT_W-1:0]         out_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic                            sat
);
    localparam int unsigned AW = IN_W + $clog2(DEC);
    localparam int unsigned RW = AW + 1;
    localparam int unsigned CW = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0]        CNT_LAST = CW'(DEC - 1);
    localparam logic signed [RW-1:0] RND      = RW'((2 ** SHIFT) / 2);
    localparam logic signed [RW-1:0] MAXV     = RW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] MINV     = RW'(-(2 ** (OUT_W - 1)));
    localparam logic [LW-1:0]        LVL_FULL = LW'(FIFO_DEPTH);

    // Stage 1: block accumulator
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sum_c;
    logic signed [AW-1:0] sum_r;
    logic                 sum_v;
    logic [CW-1:0]        cnt;

    assign acc_sum_c = acc + AW'(in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            sum_r <= '0;
            sum_v <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            cnt   <= '0;
            sum_v <= 1'b0;
        end else begin
            sum_v <= 1'b0;
            if (in_en) begin
                if (cnt == CNT_LAST) begin
                    sum_r <= acc_sum_c;
                    sum_v <= 1'b1;
                    acc   <= '0;
                    cnt   <= '0;
                end else begin
                    acc <= acc_sum_c;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // Stage 2: round half up, shift, saturate
    logic signed [RW-1:0]    rnd_c;
    logic signed [RW-1:0]    shr_c;
    logic signed [OUT_W-1:0] clip_c;
    logic                    clipped_c;
    logic signed [OUT_W-1:0] wr_data;
    logic                    wr_v;

    always_comb begin
        rnd_c     = RW'(sum_r) + RND;
        shr_c     = rnd_c >>> SHIFT;
        clip_c    = OUT_W'(shr_c);
        clipped_c = 1'b0;
        if (shr_c > MAXV) begin
            clip_c    = OUT_W'(MAXV);
            clipped_c = 1'b1;
        end else if (shr_c < MINV) begin
            clip_c    = OUT_W'(MINV);
            clipped_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_data <= '0;
            wr_v    <= 1'b0;
            sat     <= 1'b0;
        end else if (clear) begin
            wr_v <= 1'b0;
            sat  <= 1'b0;
        end else begin
            wr_data <= clip_c;
            wr_v    <= sum_v;
            sat     <= sum_v & clipped_c;
        end
    end

    // Show-ahead FIFO with registered head
    logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr_n_c;
    logic [LW-1:0]           level_n_c;
    logic signed [OUT_W-1:0] head_n_c;
    logic                    pop_c;
    logic                    push_c;
    logic                    drop_c;
    logic                    full_c;

    always_comb begin
        full_c     = (fifo_level == LVL_FULL);
        pop_c      = out_valid & out_ready;
        push_c     = wr_v & (~full_c | pop_c);
        drop_c     = wr_v & full_c & ~pop_c;
        rd_ptr_n_c = pop_c ? rd_ptr + PW'(1) : rd_ptr;
        level_n_c  = fifo_level + LW'(push_c) - LW'(pop_c);
        // A push into a FIFO that is empty after this pop becomes the head directly
        head_n_c   = (push_c && (rd_ptr_n_c == wr_ptr)) ? wr_data : mem[rd_ptr_n_c];
    end

    always_ff @(posedge clk) begin
        if (push_c && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            overflow   <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr_n_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            fifo_level <= level_n_c;
            out_valid  <= (level_n_c != '0);
            out_data   <= (level_n_c != '0) ? head_n_c : '0;
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iir_result_decimator.sv
`timescale 1ns/1ps
// Scoreboard bench for iir_result_decimator (DEC=4, SHIFT=2, OUT_W=16, FIFO_DEPTH=8).
module tb_iir_result_decimator;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               clear;
    logic               in_en;
    logic signed [23:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [3:0]         fifo_level;
    logic               overflow;
    logic               sat;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    iir_result_decimator #(
        .IN_W(24), .OUT_W(16), .DEC(4), .SHIFT(2), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_en(in_en), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .overflow(overflow), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted output is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got %0d expected no output", out_data);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(out_data) != e) begin
                    n_bad++;
                    $display("FAIL sb_data: got %0d expected %0d", out_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int x);
        in_en   = 1'b1;
        in_data = 24'(x);
        step();
        in_en   = 1'b0;
    endtask

    // Four back-to-back samples; expected decimated value queued when keep=1
    task automatic block(input int a, input int b, input int c, input int d,
                         input int exp, input bit keep);
        if (keep) exp_q.push_back(exp);
        send(a); send(b); send(c); send(d);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_en = 1'b0; in_data = '0; out_ready = 1'b1;
        idle(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sat", sat, 0);
        rst_n = 1'b1;
        idle(1);

        // 1: gapped samples 1..4 -> 3, latency two edges
        exp_q.push_back(3);
        send(1); idle(2); send(2); idle(1); send(3); idle(3); send(4);
        chk("lat_e0_valid", out_valid, 0);
        step();
        chk("lat_e1_valid", out_valid, 0);
        step();
        chk("lat_e2_valid", out_valid, 1);
        chk("lat_e2_data", out_data, 3);
        step();
        chk("t1_popped", out_valid, 0);

        // 2: back-to-back blocks and negative block
        block(1, 2, 3, 4, 3, 1);
        block(5, 6, 7, 8, 7, 1);
        block(-1, -2, -3, -4, -2, 1);
        idle(4);
        chk("t2_empty", out_valid, 0);

        // 3: saturation both ways
        block(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 32767, 1);
        step();
        chk("sat_hi_pulse", sat, 1);
        step();
        chk("sat_hi_end", sat, 0);
        chk("sat_hi_data", out_data, 32767);
        block(24'h800000, 24'h800000, 24'h800000, 24'h800000, -32768, 1);
        step();
        chk("sat_lo_pulse", sat, 1);
        step();
        chk("sat_lo_end", sat, 0);
        chk("sat_lo_data", out_data, -32768);
        idle(3);

        // 4: overflow with consumer stalled, then drain
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) block(k, k, k, k, k, k <= 8);
        idle(3);
        chk("ovf_level", fifo_level, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", out_data, 1);
        out_ready = 1'b1;
        idle(10);
        chk("ovf_drained", out_valid, 0);
        chk("ovf_drain_level", fifo_level, 0);
        chk("ovf_sticky", overflow, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // 5: full FIFO, push and pop on the same edge
        out_ready = 1'b0;
        for (int k = 10; k <= 17; k++) block(k, k, k, k, k, 1);
        idle(3);
        chk("full_level", fifo_level, 8);
        block(18, 18, 18, 18, 18, 1);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pp_level", fifo_level, 8);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", out_data, 11);
        out_ready = 1'b1;
        idle(12);
        chk("pp_drained", out_valid, 0);

        // 6a: async reset mid-block with data in the FIFO
        out_ready = 1'b0;
        block(5, 5, 5, 5, 5, 0);
        idle(2);
        send(7); send(7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_sat", sat, 0);
        #2 rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        block(4, 4, 4, 4, 4, 1);
        idle(5);
        chk("arst_after", out_valid, 0);

        // 6b: same with clear
        out_ready = 1'b0;
        block(5, 5, 5, 5, 5, 0);
        idle(2);
        send(7); send(7);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_valid", out_valid, 0);
        chk("clr_data", out_data, 0);
        chk("clr_level", fifo_level, 0);
        out_ready = 1'b1;
        block(4, 4, 4, 4, 4, 1);
        idle(5);
        chk("clr_after", out_valid, 0);

        chk("sb_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
